// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_if
//  Purpose  : Bundle of request/data inputs and scan outputs that connects the
//             display arbiter to its two requesters and the segment encoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_if;
   logic [1:0]  req;
   logic [31:0] data0;
   logic [31:0] data1;
   logic [1:0]  grant;
   logic [2:0]  sel;
   logic [3:0]  nibble;
   logic        blank;
   logic        frame_done;

   // Requester / consumer side
   modport master (
      output req, data0, data1,
      input  grant, sel, nibble, blank, frame_done
   );

   // Arbiter side
   modport slave (
      input  req, data0, data1,
      output grant, sel, nibble, blank, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/seg_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_arbiter
//  Purpose  : Frame-aligned round-robin arbiter with minimum hold time for a
//             multiplexed 7-segment display. It snapshots the owner's word
//             at each frame boundary and generates the digit scan with
//             leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_arbiter #(
   parameter int TICK_DIV = 5000,
   parameter int DIGITS   = 4,
   parameter int MIN_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   seg_scan_if.slave  bus
);

   localparam int c_CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

   localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(TICK_DIV - 1);
   localparam logic [2:0]          c_SEL_LAST  = 3'(DIGITS - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(MIN_HOLD);
   // The frame ending at this boundary counts as completed, so the owner has
   // served MIN_HOLD frames once hold has already reached MIN_HOLD-1.
   localparam logic [c_HOLD_W-1:0] c_HOLD_PREV = c_HOLD_W'(MIN_HOLD - 1);

   localparam logic [1:0] c_IDLE = 2'b00;
   localparam logic [1:0] c_OWN0 = 2'b01;
   localparam logic [1:0] c_OWN1 = 2'b10;

   logic [c_CNT_W-1:0]  cnt_q;
   logic [2:0]          sel_q;
   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic                last_q;
   logic [c_HOLD_W-1:0] hold_q;
   logic [31:0]         shadow_q;
   logic [31:0]         shadow_d;
   logic                frame_done_q;
   logic [2:0]          msd;

   logic tick;
   logic fb;
   logic hold_met;

   assign tick     = (cnt_q == c_CNT_LAST);
   assign fb       = tick && (sel_q == c_SEL_LAST);
   assign hold_met = (hold_q >= c_HOLD_PREV);

   // Slot timer and digit index; sel wraps at the last digit of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sel_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
         sel_q <= (sel_q == c_SEL_LAST) ? 3'd0 : sel_q + 3'd1;
      end else begin
         cnt_q <= cnt_q + c_CNT_W'(1);
      end
   end

   // Ownership decision evaluated for the upcoming frame boundary.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE: begin
            if (bus.req == 2'b11)  state_d = last_q ? c_OWN0 : c_OWN1;
            else if (bus.req[0])   state_d = c_OWN0;
            else if (bus.req[1])   state_d = c_OWN1;
         end
         c_OWN0: begin
            if (!bus.req[0])                state_d = bus.req[1] ? c_OWN1 : c_IDLE;
            else if (bus.req[1] && hold_met) state_d = c_OWN1;
         end
         c_OWN1: begin
            if (!bus.req[1])                state_d = bus.req[0] ? c_OWN0 : c_IDLE;
            else if (bus.req[0] && hold_met) state_d = c_OWN0;
         end
         default: state_d = c_IDLE;
      endcase
   end

   // Word captured for the next frame: the new owner's data, or dark when idle.
   always_comb begin
      shadow_d = '0;
      if (state_d == c_OWN0)      shadow_d = bus.data0;
      else if (state_d == c_OWN1) shadow_d = bus.data1;
   end

   // Arbiter state, hold/last bookkeeping and snapshot, all at frame boundaries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= c_IDLE;
         last_q       <= 1'b1;
         hold_q       <= '0;
         shadow_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= fb;
         if (fb) begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            if (state_d != state_q) begin
               hold_q <= '0;
               if (state_d != c_IDLE) last_q <= state_d[1];
            end else if (hold_q != c_HOLD_MAX) begin
               hold_q <= hold_q + c_HOLD_W'(1);
            end
         end
      end
   end

   // Most significant nonzero digit within the scanned range (0 if all zero).
   always_comb begin
      msd = 3'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (shadow_q[4*k +: 4] != 4'h0) msd = 3'(k);
      end
   end

   assign bus.grant      = state_q;
   assign bus.sel        = sel_q;
   assign bus.nibble     = shadow_q[{sel_q, 2'b00} +: 4];
   assign bus.blank      = (state_q == c_IDLE) || (sel_q > msd);
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
